// File: rtl/seq_detector_param.sv
// Serial pattern detector: compares the last PAT_W accepted bits against a loadable pattern.
// One-cycle registered match pulse. Optional saturating match counter under SEQ_DET_MATCH_COUNT_EN.
module seq_detector_param #(
  parameter int                PAT_W     = 4,
  parameter logic [PAT_W-1:0]  PAT_RESET = 4'b1011,
  parameter bit                OVERLAP   = 1'b1,
  parameter int                CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic             pattern_load,
  input  logic [PAT_W-1:0] pattern,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  localparam int               FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  pat_reg;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic              hit;

  // fill guards against the all-zero history matching before PAT_W real bits arrive
  always_comb begin
    hist_nxt = {history[PAT_W-2:0], in};
    fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
    hit      = in_valid && !pattern_load && (fill_nxt == FULL) && (hist_nxt == pat_reg);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out     <= 1'b0;
      history <= '0;
      fill    <= '0;
      pat_reg <= PAT_RESET;
    end else begin
      out <= 1'b0;
      if (pattern_load) begin
        pat_reg <= pattern;
        history <= '0;
        fill    <= '0;
      end else if (in_valid) begin
        out <= hit;
        if (hit && !OVERLAP) begin
          history <= '0;
          fill    <= '0;
        end else begin
          history <= hist_nxt;
          fill    <= fill_nxt;
        end
      end
    end
  end

`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (hit && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign match_count = cnt;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: overlapping, non-overlapping and 2-bit-counter instances share stimulus.
module tb_seq_detector_param;

`ifdef SEQ_DET_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in = 1'b0;
  logic       pattern_load = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic       out_ov, out_nov, out_c2;
  logic [7:0] cnt_ov, cnt_nov;
  logic [1:0] cnt_c2;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  seq_detector_param #(.PAT_W(4), .PAT_RESET(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in(in),
    .pattern_load(pattern_load), .pattern(pattern), .out(out_ov), .match_count(cnt_ov));

  seq_detector_param #(.PAT_W(4), .PAT_RESET(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in(in),
    .pattern_load(pattern_load), .pattern(pattern), .out(out_nov), .match_count(cnt_nov));

  seq_detector_param #(.PAT_W(4), .PAT_RESET(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in(in),
    .pattern_load(pattern_load), .pattern(pattern), .out(out_c2), .match_count(cnt_c2));

  // One clock edge with the given inputs; outputs are settled 1 time unit later.
  task automatic step(input logic v, input logic b);
    in_valid = v;
    in = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    pattern_load = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (out_ov !== 1'b0 || out_nov !== 1'b0 || out_c2 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_out: got %b%b%b expected 000", out_ov, out_nov, out_c2);
    end
    compared++;
    if (cnt_ov !== 8'd0 || cnt_nov !== 8'd0 || cnt_c2 !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", cnt_ov, cnt_nov, cnt_c2);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits    = 7'b1011011;
    logic [6:0] exp_ov  = 7'b0001001;
    logic [6:0] exp_nov = 7'b0001000;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, bits[6-i]);
      compared++;
      if (out_ov !== exp_ov[6-i]) begin
        mismatched++;
        $display("FAIL overlap_out_ov bit%0d: got %b expected %b", i + 1, out_ov, exp_ov[6-i]);
      end
      compared++;
      if (out_nov !== exp_nov[6-i]) begin
        mismatched++;
        $display("FAIL overlap_out_nov bit%0d: got %b expected %b", i + 1, out_nov, exp_nov[6-i]);
      end
    end
    compared++;
    if (cnt_ov !== (CNT_EN ? 8'd2 : 8'd0)) begin
      mismatched++;
      $display("FAIL overlap_cnt_ov: got %0d expected %0d", cnt_ov, CNT_EN ? 2 : 0);
    end
    compared++;
    if (cnt_nov !== (CNT_EN ? 8'd1 : 8'd0)) begin
      mismatched++;
      $display("FAIL overlap_cnt_nov: got %0d expected %0d", cnt_nov, CNT_EN ? 1 : 0);
    end
    step(1'b0, 1'b1);
    compared++;
    if (out_ov !== 1'b0) begin
      mismatched++;
      $display("FAIL overlap_idle_out: got %b expected 0", out_ov);
    end
  endtask

  task automatic test_zero_pattern();
    logic [5:0] exp_ov  = 6'b000111;
    logic [5:0] exp_nov = 6'b000100;
    do_reset();
    pattern = 4'b0000;
    pattern_load = 1'b1;
    step(1'b0, 1'b0);
    pattern_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      compared++;
      if (out_ov !== exp_ov[5-i]) begin
        mismatched++;
        $display("FAIL zero_out_ov bit%0d: got %b expected %b", i + 1, out_ov, exp_ov[5-i]);
      end
      compared++;
      if (out_nov !== exp_nov[5-i]) begin
        mismatched++;
        $display("FAIL zero_out_nov bit%0d: got %b expected %b", i + 1, out_nov, exp_nov[5-i]);
      end
    end
  endtask

  task automatic test_gap();
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      compared++;
      if (out_ov !== 1'b0 || out_nov !== 1'b0) begin
        mismatched++;
        $display("FAIL gap_idle cyc%0d: got %b%b expected 00", i, out_ov, out_nov);
      end
    end
    step(1'b1, 1'b1);
    compared++;
    if (out_ov !== 1'b0) begin
      mismatched++;
      $display("FAIL gap_bit3: got %b expected 0", out_ov);
    end
    step(1'b1, 1'b1);
    compared++;
    if (out_ov !== 1'b1 || out_nov !== 1'b1) begin
      mismatched++;
      $display("FAIL gap_match: got %b%b expected 11", out_ov, out_nov);
    end
  endtask

  task automatic test_load_priority();
    logic [3:0] bits = 4'b1011;
    logic [3:0] exp  = 4'b0001;
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    pattern = 4'b1011;
    pattern_load = 1'b1;
    step(1'b1, 1'b1);
    pattern_load = 1'b0;
    compared++;
    if (out_ov !== 1'b0 || out_nov !== 1'b0) begin
      mismatched++;
      $display("FAIL load_prio_out: got %b%b expected 00", out_ov, out_nov);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bits[3-i]);
      compared++;
      if (out_ov !== exp[3-i]) begin
        mismatched++;
        $display("FAIL load_after bit%0d: got %b expected %b", i + 1, out_ov, exp[3-i]);
      end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    reset = 1'b0;
    step(1'b1, 1'b1);
    reset = 1'b1;
    compared++;
    if (out_ov !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_during: got %b expected 0", out_ov);
    end
    step(1'b1, 1'b1);
    compared++;
    if (out_ov !== 1'b0 || out_nov !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_after: got %b%b expected 00", out_ov, out_nov);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] bits = 16'b1011011011011011;
    logic [1:0]  exp_c2;
    int          n = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, bits[15-i]);
      if (i == 3 || (i > 3 && (i - 3) % 3 == 0)) begin
        n++;
        exp_c2 = CNT_EN ? ((n > 3) ? 2'd3 : 2'(n)) : 2'd0;
        compared++;
        if (out_c2 !== 1'b1) begin
          mismatched++;
          $display("FAIL sat_out match%0d: got %b expected 1", n, out_c2);
        end
        compared++;
        if (cnt_c2 !== exp_c2) begin
          mismatched++;
          $display("FAIL sat_cnt_c2 match%0d: got %0d expected %0d", n, cnt_c2, exp_c2);
        end
        compared++;
        if (cnt_ov !== (CNT_EN ? 8'(n) : 8'd0)) begin
          mismatched++;
          $display("FAIL sat_cnt_ov match%0d: got %0d expected %0d", n, cnt_ov, CNT_EN ? n : 0);
        end
      end
    end
    pattern = 4'b0110;
    pattern_load = 1'b1;
    step(1'b0, 1'b0);
    pattern_load = 1'b0;
    compared++;
    if (cnt_c2 !== (CNT_EN ? 2'd3 : 2'd0)) begin
      mismatched++;
      $display("FAIL sat_cnt_after_load: got %0d expected %0d", cnt_c2, CNT_EN ? 3 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_zero_pattern();
    test_gap();
    test_load_priority();
    test_midreset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
